// File: rtl/arp_rx.sv
// ARP receiver on a GMII byte stream: filters ARP requests/replies addressed to this
// node and reports the sender hardware/protocol address of each accepted frame.
module arp_rx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = 32'hC0_A8_00_EA
) (
    input  logic        gmii_rxc,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        arp_rx_done,
    output logic        arp_rx_type,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        uni_ok_q, uni_ok_d;
    logic        bc_ok_q, bc_ok_d;
    logic        type_sh_q, type_sh_d;
    logic [47:0] mac_sh_q, mac_sh_d;
    logic [31:0] ip_sh_q, ip_sh_d;
    logic        done_q, done_d;
    logic        type_q, type_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [31:0] src_ip_q, src_ip_d;

    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    mac_byte = BOARD_MAC[47:40];
            3'd1:    mac_byte = BOARD_MAC[39:32];
            3'd2:    mac_byte = BOARD_MAC[31:24];
            3'd3:    mac_byte = BOARD_MAC[23:16];
            3'd4:    mac_byte = BOARD_MAC[15:8];
            default: mac_byte = BOARD_MAC[7:0];
        endcase
    endfunction

    function automatic logic [7:0] ip_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    ip_byte = BOARD_IP[31:24];
            2'd1:    ip_byte = BOARD_IP[23:16];
            2'd2:    ip_byte = BOARD_IP[15:8];
            default: ip_byte = BOARD_IP[7:0];
        endcase
    endfunction

    // Fixed ARP-over-Ethernet header: HTYPE, PTYPE, HLEN, PLEN, OPER high byte
    function automatic logic [7:0] arp_hdr_byte(input logic [2:0] idx);
        case (idx)
            3'd1:    arp_hdr_byte = 8'h01;
            3'd2:    arp_hdr_byte = 8'h08;
            3'd4:    arp_hdr_byte = 8'h06;
            3'd5:    arp_hdr_byte = 8'h04;
            default: arp_hdr_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        uni_ok_d  = uni_ok_q;
        bc_ok_d   = bc_ok_q;
        type_sh_d = type_sh_q;
        mac_sh_d  = mac_sh_q;
        ip_sh_d   = ip_sh_q;
        done_d    = 1'b0;
        type_d    = type_q;
        src_mac_d = src_mac_q;
        src_ip_d  = src_ip_q;
        case (state_q)
            IDLE: begin
                if (gmii_rx_dv)
                    state_d = (gmii_rxd == 8'h55) ? PREAMBLE : RX_END;
            end
            // First 0x55 was consumed in IDLE, so six more precede the SFD
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (cnt_q < 5'd6) begin
                    if (gmii_rxd != 8'h55) state_d = RX_END;
                end else if (gmii_rxd == 8'hD5) begin
                    state_d  = ETH_HEAD;
                    uni_ok_d = 1'b1;
                    bc_ok_d  = 1'b1;
                end else begin
                    state_d = RX_END;
                end
            end
            ETH_HEAD: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (cnt_q < 5'd6) begin
                    uni_ok_d = uni_ok_q && (gmii_rxd == mac_byte(cnt_q[2:0]));
                    bc_ok_d  = bc_ok_q && (gmii_rxd == 8'hFF);
                    if (!uni_ok_d && !bc_ok_d) state_d = RX_END;
                end else if (cnt_q == 5'd12) begin
                    if (gmii_rxd != 8'h08) state_d = RX_END;
                end else if (cnt_q == 5'd13) begin
                    state_d = (gmii_rxd == 8'h06) ? ARP_DATA : RX_END;
                end
            end
            ARP_DATA: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (cnt_q < 5'd7) begin
                    if (gmii_rxd != arp_hdr_byte(cnt_q[2:0])) state_d = RX_END;
                end else if (cnt_q == 5'd7) begin
                    if (gmii_rxd == 8'h01)      type_sh_d = 1'b0;
                    else if (gmii_rxd == 8'h02) type_sh_d = 1'b1;
                    else                        state_d   = RX_END;
                end else if (cnt_q <= 5'd13) begin
                    mac_sh_d = {mac_sh_q[39:0], gmii_rxd};
                end else if (cnt_q <= 5'd17) begin
                    ip_sh_d = {ip_sh_q[23:0], gmii_rxd};
                end else if (cnt_q >= 5'd24) begin
                    if (gmii_rxd != ip_byte(cnt_q[1:0])) begin
                        state_d = RX_END;
                    end else if (cnt_q == 5'd27) begin
                        done_d    = 1'b1;
                        type_d    = type_sh_q;
                        src_mac_d = mac_sh_q;
                        src_ip_d  = ip_sh_q;
                        state_d   = RX_END;
                    end
                end
            end
            RX_END: begin
                if (!gmii_rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cnt_d = 5'd0;
        if (state_d == state_q &&
            (state_q == PREAMBLE || state_q == ETH_HEAD || state_q == ARP_DATA))
            cnt_d = cnt_q + 5'd1;
    end

    always_ff @(posedge gmii_rxc) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            uni_ok_q  <= 1'b0;
            bc_ok_q   <= 1'b0;
            type_sh_q <= 1'b0;
            mac_sh_q  <= 48'd0;
            ip_sh_q   <= 32'd0;
            done_q    <= 1'b0;
            type_q    <= 1'b0;
            src_mac_q <= 48'd0;
            src_ip_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            uni_ok_q  <= uni_ok_d;
            bc_ok_q   <= bc_ok_d;
            type_sh_q <= type_sh_d;
            mac_sh_q  <= mac_sh_d;
            ip_sh_q   <= ip_sh_d;
            done_q    <= done_d;
            type_q    <= type_d;
            src_mac_q <= src_mac_d;
            src_ip_q  <= src_ip_d;
        end
    end

    assign arp_rx_done = done_q;
    assign arp_rx_type = type_q;
    assign src_mac     = src_mac_q;
    assign src_ip      = src_ip_q;
endmodule

// File: tb/tb_arp_rx.sv
// Bench for arp_rx: directed and random ARP frames judged by a frame-level model
// that decides acceptance from the whole byte list.
`timescale 1ns/1ps
module tb_arp_rx;
    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = 32'hC0_A8_00_EA;
    localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;

    logic        gmii_rxc   = 1'b0;
    logic        rst_n      = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd   = 8'h00;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    int          vectors = 0;
    int          errors  = 0;
    logic        exp_type = 1'b0;
    logic [47:0] exp_mac  = 48'd0;
    logic [31:0] exp_ip   = 32'd0;
    logic [7:0]  frame[$];

    arp_rx dut (
        .gmii_rxc    (gmii_rxc),
        .rst_n       (rst_n),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rxd    (gmii_rxd),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .src_mac     (src_mac),
        .src_ip      (src_ip)
    );

    always #4 gmii_rxc = ~gmii_rxc;

    // Builds preamble, Ethernet header, ARP body, padding and a dummy FCS into frame
    task automatic make_frame(input logic [47:0] dst, input logic [15:0] etype,
                              input logic [15:0] oper, input logic [47:0] smac,
                              input logic [31:0] sip, input logic [31:0] tip,
                              input int npre, input int pad);
        frame.delete();
        for (int i = 0; i < npre; i++) frame.push_back(8'h55);
        frame.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frame.push_back(dst[8*i +: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(8'($urandom));
        frame.push_back(etype[15:8]);
        frame.push_back(etype[7:0]);
        frame.push_back(8'h00); frame.push_back(8'h01);
        frame.push_back(8'h08); frame.push_back(8'h00);
        frame.push_back(8'h06); frame.push_back(8'h04);
        frame.push_back(oper[15:8]);
        frame.push_back(oper[7:0]);
        for (int i = 5; i >= 0; i--) frame.push_back(smac[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frame.push_back(sip[8*i +: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(8'h00);
        for (int i = 3; i >= 0; i--) frame.push_back(tip[8*i +: 8]);
        for (int i = 0; i < pad + 4; i++) frame.push_back(8'($urandom));
    endtask

    // Frame-level acceptance: fixed byte offsets of an Ethernet/ARP frame
    function automatic bit model_accept(input int len);
        logic [47:0] dst;
        logic [15:0] oper;
        logic [31:0] tip;
        if (len < 50 || frame.size() < 50) return 1'b0;
        for (int i = 0; i < 7; i++) if (frame[i] != 8'h55) return 1'b0;
        if (frame[7] != 8'hD5) return 1'b0;
        dst = {frame[8], frame[9], frame[10], frame[11], frame[12], frame[13]};
        if (dst != BOARD_MAC && dst != BCAST) return 1'b0;
        if ({frame[20], frame[21]} != 16'h0806) return 1'b0;
        if ({frame[22], frame[23]} != 16'h0001) return 1'b0;
        if ({frame[24], frame[25]} != 16'h0800) return 1'b0;
        if (frame[26] != 8'h06 || frame[27] != 8'h04) return 1'b0;
        oper = {frame[28], frame[29]};
        if (oper != 16'h0001 && oper != 16'h0002) return 1'b0;
        tip = {frame[46], frame[47], frame[48], frame[49]};
        return tip == BOARD_IP;
    endfunction

    // Drives len bytes of frame (then one dv-low cycle); rst_at >= 0 pulses reset on that byte
    task automatic send_frame(input int len, input int rst_at, input string name);
        bit          acc;
        int          n;
        logic        new_type;
        logic [47:0] new_mac;
        logic [31:0] new_ip;
        n   = (len < frame.size()) ? len : frame.size();
        acc = (rst_at < 0) && model_accept(n);
        new_type = 1'b0;
        new_mac  = 48'd0;
        new_ip   = 32'd0;
        if (acc) begin
            new_type = ({frame[28], frame[29]} == 16'h0002);
            new_mac  = {frame[30], frame[31], frame[32], frame[33], frame[34], frame[35]};
            new_ip   = {frame[36], frame[37], frame[38], frame[39]};
        end
        for (int i = 0; i <= n; i++) begin
            @(negedge gmii_rxc);
            vectors++;
            if (arp_rx_done !== (acc && (i == 50))) begin
                errors++;
                $display("[TB] FAIL %s done at byte slot %0d: got %b expected %b",
                         name, i, arp_rx_done, (acc && (i == 50)));
            end
            if (rst_at >= 0 && i == rst_at + 1) begin
                exp_type = 1'b0;
                exp_mac  = 48'd0;
                exp_ip   = 32'd0;
                vectors += 3;
                if (arp_rx_type !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s type after reset: got %b expected 0", name, arp_rx_type);
                end
                if (src_mac !== 48'd0) begin
                    errors++;
                    $display("[TB] FAIL %s src_mac after reset: got %h expected 0", name, src_mac);
                end
                if (src_ip !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL %s src_ip after reset: got %h expected 0", name, src_ip);
                end
            end
            if (i < n) begin
                gmii_rx_dv = 1'b1;
                gmii_rxd   = frame[i];
                rst_n      = (i == rst_at) ? 1'b0 : 1'b1;
            end else begin
                gmii_rx_dv = 1'b0;
                gmii_rxd   = 8'h00;
                rst_n      = 1'b1;
            end
        end
        if (acc) begin
            exp_type = new_type;
            exp_mac  = new_mac;
            exp_ip   = new_ip;
        end
        vectors += 3;
        if (arp_rx_type !== exp_type) begin
            errors++;
            $display("[TB] FAIL %s arp_rx_type: got %b expected %b", name, arp_rx_type, exp_type);
        end
        if (src_mac !== exp_mac) begin
            errors++;
            $display("[TB] FAIL %s src_mac: got %h expected %h", name, src_mac, exp_mac);
        end
        if (src_ip !== exp_ip) begin
            errors++;
            $display("[TB] FAIL %s src_ip: got %h expected %h", name, src_ip, exp_ip);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        gmii_rx_dv = 1'b0;
        repeat (3) @(negedge gmii_rxc);
        rst_n = 1'b1;
        vectors += 4;
        if (arp_rx_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset done: got %b expected 0", arp_rx_done);
        end
        if (arp_rx_type !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset type: got %b expected 0", arp_rx_type);
        end
        if (src_mac !== 48'd0) begin
            errors++;
            $display("[TB] FAIL reset src_mac: got %h expected 0", src_mac);
        end
        if (src_ip !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset src_ip: got %h expected 0", src_ip);
        end
    endtask

    task automatic test_broadcast_request();
        make_frame(BCAST, 16'h0806, 16'h0001, 48'h000A3501FEC0, 32'hC0A80002, BOARD_IP, 7, 18);
        send_frame(frame.size(), -1, "bcast_req");
        vectors += 2;
        if (src_mac !== 48'h000A3501FEC0 || arp_rx_type !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bcast_req literal mac/type: got %h/%b expected 000a3501fec0/0",
                     src_mac, arp_rx_type);
        end
        if (src_ip !== 32'hC0A80002) begin
            errors++;
            $display("[TB] FAIL bcast_req literal ip: got %h expected c0a80002", src_ip);
        end
    endtask

    task automatic test_unicast_reply();
        make_frame(BOARD_MAC, 16'h0806, 16'h0002, {16'h02AB, $urandom}, $urandom, BOARD_IP, 7, 5);
        send_frame(frame.size(), -1, "ucast_reply");
    endtask

    task automatic test_filters();
        make_frame(BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80009, 32'hC0A80064, 7, 2);
        send_frame(frame.size(), -1, "bad_target_ip");
        make_frame(BCAST, 16'h0800, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80009, BOARD_IP, 7, 2);
        send_frame(frame.size(), -1, "bad_ethertype");
        make_frame(48'h001122334456, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80009,
                   BOARD_IP, 7, 2);
        send_frame(frame.size(), -1, "bad_dest_mac");
    endtask

    task automatic test_abort_back_to_back();
        make_frame(BCAST, 16'h0806, 16'h0002, 48'h112233445566, 32'hC0A80011, BOARD_IP, 7, 0);
        send_frame(42, -1, "abort_arp20");
        make_frame(BOARD_MAC, 16'h0806, 16'h0001, 48'h665544332211, 32'hC0A80012, BOARD_IP, 7, 0);
        send_frame(frame.size(), -1, "after_abort");
        make_frame(BCAST, 16'h0806, 16'h0002, 48'h0123456789AB, 32'hC0A80013, BOARD_IP, 7, 0);
        send_frame(frame.size(), -1, "back_to_back");
    endtask

    task automatic test_bad_preamble_oper();
        make_frame(BCAST, 16'h0806, 16'h0001, 48'hAAAAAAAAAAAA, 32'hC0A80020, BOARD_IP, 6, 3);
        send_frame(frame.size(), -1, "short_preamble");
        make_frame(BCAST, 16'h0806, 16'h0003, 48'hBBBBBBBBBBBB, 32'hC0A80021, BOARD_IP, 7, 3);
        send_frame(frame.size(), -1, "oper3");
    endtask

    task automatic test_reset_mid_frame();
        make_frame(BCAST, 16'h0806, 16'h0002, 48'h000A3501FEC0, 32'hC0A80030, BOARD_IP, 7, 4);
        send_frame(frame.size(), 31, "reset_arp10");
        make_frame(BCAST, 16'h0806, 16'h0001, 48'h000A3501FEC1, 32'hC0A80031, BOARD_IP, 7, 4);
        send_frame(frame.size(), -1, "after_reset");
    endtask

    task automatic test_random(input int count);
        for (int k = 0; k < count; k++) begin
            logic [47:0] dst;
            logic [15:0] etype;
            logic [15:0] oper;
            logic [31:0] tip;
            logic [63:0] rnd;
            int          r, npre, len, idx;
            rnd = {$urandom, $urandom};
            r   = $urandom_range(0, 9);
            dst = (r < 4) ? BOARD_MAC : (r < 8) ? BCAST :
                  (r < 9) ? (BOARD_MAC ^ (48'd1 << $urandom_range(0, 47))) : rnd[47:0];
            etype = ($urandom_range(0, 9) < 9) ? 16'h0806 : 16'h0800;
            r     = $urandom_range(0, 9);
            oper  = (r < 5) ? 16'h0001 : (r < 9) ? 16'h0002 : 16'h0003;
            tip   = ($urandom_range(0, 9) < 8) ? BOARD_IP
                                                : (BOARD_IP ^ (32'd1 << $urandom_range(0, 31)));
            r     = $urandom_range(0, 9);
            npre  = (r == 0) ? 6 : (r == 1) ? 8 : 7;
            make_frame(dst, etype, oper, {16'h0000, $urandom}, $urandom, tip, npre,
                       int'($urandom_range(0, 10)));
            if ($urandom_range(0, 9) == 0) begin
                idx = $urandom_range(0, frame.size() - 1);
                frame[idx] = frame[idx] ^ (8'd1 << $urandom_range(0, 7));
            end
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, frame.size() - 1))
                                              : frame.size();
            send_frame(len, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_broadcast_request();
        test_unicast_reply();
        test_filters();
        test_abort_back_to_back();
        test_bad_preamble_oper();
        test_reset_mid_frame();
        test_random(60);
        repeat (2) @(negedge gmii_rxc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/arp_rx.md
ARP_RX -- requirements
Module: arp_rx

Interface
REQ-001 BOARD_MAC, 48'h00_11_22_33_44_55, local MAC address used for destination filtering.
REQ-002 BOARD_IP, 32'hC0_A8_00_EA (192.168.0.234), local IPv4 address used for target-IP filtering.
REQ-003 gmii_rxc  input  1  GMII receive clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 gmii_rx_dv  input  1  receive data valid from PHY.
REQ-006 gmii_rxd  input  8  receive byte from PHY, valid when gmii_rx_dv=1.
REQ-007 arp_rx_done  output  1  one-cycle pulse: valid ARP frame addressed to this node received.
REQ-008 arp_rx_type  output  1  0 = request received, 1 = reply received; valid while arp_rx_done=1, held afterwards.
REQ-009 src_mac  output  48  ARP sender hardware address of last accepted frame.
REQ-010 src_ip  output  32  ARP sender protocol address of last accepted frame.

Function
REQ-011 FSM states SHALL be IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END, with a byte counter reset to 0 on every state change.
REQ-012 IDLE: on gmii_rx_dv=1 with gmii_rxd=0x55 -> PREAMBLE (byte counted as preamble byte 1); dv=1 with any other byte -> RX_END.
REQ-013 PREAMBLE: SHALL require exactly 7 bytes of 0x55 followed by 0xD5 -> ETH_HEAD; any deviation -> RX_END.
REQ-014 ETH_HEAD: 14 bytes; dest MAC SHALL equal BOARD_MAC or FF:FF:FF:FF:FF:FF; EtherType SHALL equal 0x0806; failure of either -> RX_END; pass after byte 14 -> ARP_DATA.
REQ-015 ARP_DATA: 28 bytes; HTYPE=0x0001, PTYPE=0x0800, HLEN=6, PLEN=4, OPER in {0x0001, 0x0002}, target IP (bytes 25-28) = BOARD_IP; any mismatch -> frame rejected, RX_END.
REQ-016 Sender MAC (bytes 9-14) and sender IP (bytes 15-18) SHALL be captured MSB-first into internal shadow registers; src_mac/src_ip SHALL update from shadows only on acceptance.
REQ-017 On acceptance, arp_rx_done SHALL pulse high for exactly one cycle in the cycle after ARP byte 28 is sampled; arp_rx_type, src_mac, src_ip SHALL update in that same cycle; FSM -> RX_END.
REQ-018 arp_rx_type SHALL be 0 for OPER=0x0001 and 1 for OPER=0x0002.
REQ-019 RX_END: ignore remaining bytes (padding, FCS); on gmii_rx_dv=0 -> IDLE.
REQ-020 gmii_rx_dv falling in PREAMBLE, ETH_HEAD or ARP_DATA SHALL abort to IDLE with no done pulse and no output update.
REQ-021 FCS SHALL NOT be checked; frames shorter than the ARP body SHALL be dropped per REQ-020.
REQ-022 Back-to-back frames separated by one dv-low cycle SHALL both be processed.
REQ-023 arp_rx_done SHALL never assert for two consecutive cycles.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force state IDLE, counter 0, arp_rx_done=0, arp_rx_type=0, src_mac=0, src_ip=0, shadows 0.
REQ-025 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL ignore bytes until dv low then a fresh preamble (REQ-012 handles dv high via RX_END).

Verification
REQ-026 Broadcast request, sender 00:0A:35:01:FE:C0 / 192.168.0.2, target IP 192.168.0.234 -> one done pulse, type=0, src_mac=0x000A3501FEC0, src_ip=0xC0A80002, exactly 1 cycle after target IP last byte.
REQ-027 Unicast reply to 00:11:22:33:44:55, OPER=2 -> done pulse, type=1, outputs updated.
REQ-028 Request with target IP 192.168.0.100 or EtherType 0x0800 or dest MAC 00:11:22:33:44:56 -> no done, outputs unchanged.
REQ-029 dv dropped after ARP byte 20 followed by a valid frame one cycle later -> no pulse for first, one pulse for second.
REQ-030 Preamble of six 0x55 then 0xD5, and OPER=0x0003 -> no done pulse.
REQ-031 rst_n low for one cycle during ARP byte 10 -> all outputs 0, no pulse for that frame, next valid frame accepted.
